// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives byte/half/word loads and stores over a req/ack
// data-memory handshake and returns a registered one-cycle result to MEM/WB.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        misalign_exc,
    output logic        bus_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;
    logic [3:0]       dmem_wstrb_q, dmem_wstrb_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       rd_out_q, rd_out_d;
    logic             reg_write_out_q, reg_write_out_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;
    // Instruction context captured at request time for the completion cycle
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lane_q, lane_d;
    logic [4:0]       rd_lat_q, rd_lat_d;
    logic             rw_lat_q, rw_lat_d;
    logic             read_lat_q, read_lat_d;

    logic        start, misaligned, last_wait, timeout_hit;
    logic [31:0] st_wdata, rd_shift, ld_data;
    logic [3:0]  st_wstrb;

    assign start       = in_valid & (mem_read | mem_write);
    assign last_wait   = (cnt_q == CNT_LAST);
    assign timeout_hit = (state_q == BUSY) & ~dmem_ack & last_wait;
    assign rd_shift    = dmem_rdata >> {lane_q, 3'b000};

    always_ff @(posedge clk) begin
        // NOTE: every flop, including the latched context, is reset so a late ack after reset finds a clean IDLE.
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            dmem_wstrb_q    <= '0;
            out_valid_q     <= 1'b0;
            result_q        <= '0;
            rd_out_q        <= '0;
            reg_write_out_q <= 1'b0;
            misalign_q      <= 1'b0;
            bus_err_q       <= 1'b0;
            funct3_q        <= '0;
            lane_q          <= '0;
            rd_lat_q        <= '0;
            rw_lat_q        <= 1'b0;
            read_lat_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            dmem_wstrb_q    <= dmem_wstrb_d;
            out_valid_q     <= out_valid_d;
            result_q        <= result_d;
            rd_out_q        <= rd_out_d;
            reg_write_out_q <= reg_write_out_d;
            misalign_q      <= misalign_d;
            bus_err_q       <= bus_err_d;
            funct3_q        <= funct3_d;
            lane_q          <= lane_d;
            rd_lat_q        <= rd_lat_d;
            rw_lat_q        <= rw_lat_d;
            read_lat_q      <= read_lat_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !misaligned) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (dmem_ack || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            3'b001, 3'b101: misaligned = alu_result[0];
            3'b010:         misaligned = |alu_result[1:0];
            default:        misaligned = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_wstrb = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2_data;
                st_wstrb = 4'b1111;
            end
        endcase

        case (funct3_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin
        stall           = 1'b0;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        dmem_wstrb_d    = dmem_wstrb_q;
        out_valid_d     = 1'b0;
        result_d        = result_q;
        rd_out_d        = rd_out_q;
        reg_write_out_d = reg_write_out_q;
        misalign_d      = 1'b0;
        bus_err_d       = 1'b0;
        funct3_d        = funct3_q;
        lane_d          = lane_q;
        rd_lat_d        = rd_lat_q;
        rw_lat_d        = rw_lat_q;
        read_lat_d      = read_lat_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !start) begin
                    out_valid_d     = 1'b1;
                    result_d        = alu_result;
                    rd_out_d        = rd_in;
                    reg_write_out_d = reg_write_in;
                end else if (start && misaligned) begin
                    out_valid_d     = 1'b1;
                    misalign_d      = 1'b1;
                    result_d        = alu_result;
                    rd_out_d        = rd_in;
                    reg_write_out_d = 1'b0;
                end else if (start) begin
                    stall        = 1'b1;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = mem_write;
                    dmem_addr_d  = {alu_result[31:2], 2'b00};
                    dmem_wdata_d = st_wdata;
                    dmem_wstrb_d = mem_write ? st_wstrb : 4'b0000;
                    funct3_d     = funct3;
                    lane_d       = alu_result[1:0];
                    rd_lat_d     = rd_in;
                    rw_lat_d     = reg_write_in;
                    read_lat_d   = mem_read;
                end
            end
            BUSY: begin
                // Stall drops in the final wait cycle so the abort and upstream advance share an edge
                stall = ~dmem_ack & ~last_wait;
                if (dmem_ack) begin
                    dmem_req_d      = 1'b0;
                    dmem_we_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    rd_out_d        = rd_lat_q;
                    result_d        = read_lat_q ? ld_data : 32'd0;
                    reg_write_out_d = read_lat_q & rw_lat_q;
                end else if (timeout_hit) begin
                    dmem_req_d      = 1'b0;
                    dmem_we_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    bus_err_d       = 1'b1;
                    rd_out_d        = rd_lat_q;
                    result_d        = 32'd0;
                    reg_write_out_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign dmem_wstrb    = dmem_wstrb_q;
    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign rd_out        = rd_out_q;
    assign reg_write_out = reg_write_out_q;
    assign misalign_exc  = misalign_q;
    assign bus_err       = bus_err_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX stage. Consumes the ALU result (effective address) and rs2 data (store data).
- Runs byte, half and word loads/stores on the data memory through a req/ack handshake, and stalls upstream while an access is outstanding.
- Returns sign/zero-extended load data, or passes the ALU result through, to the MEM/WB register as a registered one-cycle result.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for dmem_ack before aborting with bus_err (must be >=1).
- CNT_W, 5, width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  EX result valid this cycle.
- alu_result  in  32  address for mem ops; pass-through value otherwise.
- rs2_data  in  32  store data.
- mem_read  in  1  load.
- mem_write  in  1  store (mem_read and mem_write never both high).
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_in  in  5  destination register.
- reg_write_in  in  1  writeback enable.
- stall  out  1  hold EX and earlier stages (combinational).
- dmem_req  out  1  memory request (registered).
- dmem_we  out  1  write request.
- dmem_addr  out  32  {addr[31:2],2'b00}.
- dmem_wdata  out  32  store data replicated to lanes.
- dmem_wstrb  out  4  byte-lane write strobes.
- dmem_ack  in  1  request completes this cycle; dmem_rdata valid.
- dmem_rdata  in  32  read word.
- out_valid  out  1  result valid pulse.
- result  out  32  extended load data or alu_result.
- rd_out  out  5  destination register.
- reg_write_out  out  1  writeback enable (0 on any exception).
- misalign_exc  out  1  misaligned access (valid with out_valid).
- bus_err  out  1  ack timeout (valid with out_valid).

Behaviour:
- Reset: state=IDLE, all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, out_valid, result, rd_out, reg_write_out, misalign_exc, bus_err), counter 0. Reset mid-access drops dmem_req at that edge; any late ack is ignored.
- Define start = in_valid & (mem_read|mem_write).
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- State IDLE:
  - in_valid & !start: next edge out_valid=1, result=alu_result, rd/reg_write passed through. No stall.
  - start & misaligned: no request. Next edge out_valid=1, misalign_exc=1, reg_write_out=0, result=alu_result. No stall.
  - start & aligned: stall=1. Latch funct3, addr[1:0], rd, reg_write and mem_read. Next edge: state=BUSY, dmem_req=1, dmem_we=mem_write, dmem_addr set, counter=0.
  - Store B: wdata={4{rs2[7:0]}}, wstrb=1<<addr[1:0].
  - Store H: wdata={2{rs2[15:0]}}, wstrb=addr[1]?1100:0011.
  - Store W: wdata=rs2, wstrb=1111.
  - Loads: wstrb=0000.
  - !in_valid: out_valid=0 next edge.
- State BUSY:
  - stall = !dmem_ack. in_valid is ignored (it holds the same instruction).
  - On dmem_ack: next edge dmem_req=0, state=IDLE, out_valid=1.
    - Loads: result = lane selected by the latched addr[1:0], sign-extended (B/H) or zero-extended (BU/HU).
    - Stores: result=0, reg_write_out=0.
  - No ack: counter++. When counter==TIMEOUT-1 and still no ack: next edge dmem_req=0, state=IDLE, out_valid=1, bus_err=1, reg_write_out=0, stall released in that cycle.
- Minimum latency for aligned mem op: start cycle + ack cycle. out_valid is 2 edges after start when ack arrives in the first BUSY cycle.
- Non-mem and misaligned ops: 1 edge.
- out_valid, misalign_exc and bus_err are single-cycle pulses.
- dmem_req is held stable with constant addr, wdata and wstrb until ack or timeout.
- Ack while in IDLE is ignored.

Test Plan:
- Word load, addr=0x100, ack 3 cycles after req, rdata=0xDEADBEEF:
  - stall high for 4 cycles; dmem_addr=0x100, wstrb=0000.
  - out_valid one cycle after ack, result=0xDEADBEEF.
- Byte loads addr=0x103, rdata=0x80112233, ack in first BUSY cycle:
  - LB -> result=0xFFFFFF80.
  - LBU -> 0x00000080.
  - Latency 2 edges.
- SH addr=0x22, rs2=0x1234ABCD:
  - dmem_we=1, dmem_addr=0x20, wdata=0xABCDABCD, wstrb=1100.
  - out_valid with reg_write_out=0.
- LW addr=0x102:
  - No dmem_req.
  - Next edge out_valid=1, misalign_exc=1, reg_write_out=0, stall never high.
- TIMEOUT=4, no ack:
  - dmem_req high 4 cycles then drops.
  - out_valid=1, bus_err=1.
  - A subsequent pass-through op (alu_result=0x55) completes with result=0x55.
- rst asserted in second BUSY cycle:
  - All outputs 0 next edge.
  - Ack arriving one cycle later produces no out_valid.
